// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter/sequencer in front of one
// single-port asynchronous memory (1024 x 32, word index = address[11:2]).
// Port 0 is instruction fetch, port 1 is data load/store.
// Optional statistics counters are built when MEM_ARB_STATS_EN is defined.
module mem_arbiter #(
    parameter int WAIT_CYCLES = 2
`ifdef MEM_ARB_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1,
    output logic [CNT_W-1:0] conflict_cnt
`endif
);

    localparam int WC_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [WC_W-1:0] WAIT_LOAD = WC_W'(WAIT_CYCLES);
    localparam logic [WC_W-1:0] CNT_ONE   = WC_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic              last_grant_r;
    logic              grant_r;
    logic              we_r;
    logic [31:0]       addr_r;
    logic [31:0]       wdata_r;
    logic [WC_W-1:0]   wait_cnt_r;
    logic [31:0]       rdata0_r;
    logic [31:0]       rdata1_r;

    logic              req_any_s;
    logic              grant_s;
    logic              sel_we_s;
    logic [31:0]       sel_addr_s;
    logic [31:0]       sel_wdata_s;
    logic              last_read_s;

    logic              mem_read_s;
    logic              mem_write_s;
    logic [31:0]       mem_address_s;
    logic [31:0]       mem_write_data_s;
    logic              ack0_s;
    logic              ack1_s;

    assign req_any_s   = req0 | req1;
    assign last_read_s = (state_r == ST_ACCESS) && (wait_cnt_r == CNT_ONE) && !we_r;

    // Pick the port to grant: a lone requester wins, a tie goes to the port not served last.
    always_comb begin
        grant_s = last_grant_r;
        if (req0 && !req1) begin
            grant_s = 1'b0;
        end else if (req1 && !req0) begin
            grant_s = 1'b1;
        end else if (req0 && req1) begin
            grant_s = ~last_grant_r;
        end else begin
            grant_s = last_grant_r;
        end
    end

    // Mux the request fields of the winning port so they can be latched at grant.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = 32'd0;
        sel_wdata_s = 32'd0;
        if (grant_s) begin
            sel_we_s    = we1;
            sel_addr_s  = addr1;
            sel_wdata_s = wdata1;
        end else begin
            sel_we_s    = we0;
            sel_addr_s  = addr0;
            sel_wdata_s = wdata0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic: reads stay in ACCESS for WAIT_CYCLES cycles, writes for one.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_any_s) begin
                    state_s = ST_ACCESS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (wait_cnt_r == CNT_ONE) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_ACCESS;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Latch the granted request and run the access-length counter; fields are frozen after grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_r <= 1'b1;
            grant_r      <= 1'b0;
            we_r         <= 1'b0;
            addr_r       <= 32'd0;
            wdata_r      <= 32'd0;
            wait_cnt_r   <= '0;
        end else if ((state_r == ST_IDLE) && req_any_s) begin
            last_grant_r <= grant_s;
            grant_r      <= grant_s;
            we_r         <= sel_we_s;
            addr_r       <= sel_addr_s;
            wdata_r      <= sel_wdata_s;
            wait_cnt_r   <= sel_we_s ? CNT_ONE : WAIT_LOAD;
        end else if (state_r == ST_ACCESS) begin
            wait_cnt_r   <= wait_cnt_r - CNT_ONE;
        end
    end

    // Capture memory read data into the granted port's register on the last ACCESS edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata0_r <= 32'd0;
            rdata1_r <= 32'd0;
        end else if (last_read_s) begin
            if (grant_r) begin
                rdata1_r <= mem_read_data;
            end else begin
                rdata0_r <= mem_read_data;
            end
        end
    end

    // FSM output decode from registered state; memory bus idles at zero outside ACCESS.
    always_comb begin
        mem_read_s       = 1'b0;
        mem_write_s      = 1'b0;
        mem_address_s    = 32'd0;
        mem_write_data_s = 32'd0;
        ack0_s           = 1'b0;
        ack1_s           = 1'b0;
        case (state_r)
            ST_ACCESS: begin
                mem_read_s       = ~we_r;
                mem_write_s      = we_r;
                mem_address_s    = addr_r;
                mem_write_data_s = we_r ? wdata_r : 32'd0;
            end
            ST_DONE: begin
                ack0_s = ~grant_r;
                ack1_s = grant_r;
            end
            default: begin
                mem_read_s = 1'b0;
            end
        endcase
    end

    assign mem_read       = mem_read_s;
    assign mem_write      = mem_write_s;
    assign mem_address    = mem_address_s;
    assign mem_write_data = mem_write_data_s;
    assign ack0           = ack0_s;
    assign ack1           = ack1_s;
    assign rdata0         = rdata0_r;
    assign rdata1         = rdata1_r;

`ifdef MEM_ARB_STATS_EN
    logic [CNT_W-1:0] grant_cnt0_r;
    logic [CNT_W-1:0] grant_cnt1_r;
    logic [CNT_W-1:0] conflict_cnt_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Saturating grant and conflict statistics, sampled on IDLE edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_cnt0_r   <= '0;
            grant_cnt1_r   <= '0;
            conflict_cnt_r <= '0;
        end else if (state_r == ST_IDLE) begin
            if (req_any_s && grant_s) begin
                grant_cnt1_r <= sat_inc(grant_cnt1_r);
            end else if (req_any_s) begin
                grant_cnt0_r <= sat_inc(grant_cnt0_r);
            end
            if (req0 && req1) begin
                conflict_cnt_r <= sat_inc(conflict_cnt_r);
            end
        end
    end

    assign grant_cnt0   = grant_cnt0_r;
    assign grant_cnt1   = grant_cnt1_r;
    assign conflict_cnt = conflict_cnt_r;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a
// behavioural 1024 x 32 asynchronous memory. Statistics checks are compiled
// in when MEM_ARB_STATS_EN is defined (counters built 2 bits wide).
module tb_mem_arbiter;

    localparam int WAIT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic        mem_read, mem_write;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
`ifdef MEM_ARB_STATS_EN
    logic [1:0]  grant_cnt0, grant_cnt1, conflict_cnt;
`endif

    logic [31:0] mem [0:1023];
    logic        pre_we;
    logic [9:0]  pre_idx;
    logic [31:0] pre_data;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(
        .WAIT_CYCLES(WAIT)
`ifdef MEM_ARB_STATS_EN
        ,
        .CNT_W(2)
`endif
    ) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
`ifdef MEM_ARB_STATS_EN
        ,
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .conflict_cnt(conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Asynchronous-read memory; writes commit on the clock edge, bench preload shares the port.
    assign mem_read_data = mem[mem_address[11:2]];
    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_address[11:2]] <= mem_write_data;
        end else if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] data);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx; pre_data = data;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic set_port(input logic port, input logic req, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            req1 = req; we1 = we; addr1 = addr; wdata1 = wdata;
        end else begin
            req0 = req; we0 = we; addr0 = addr; wdata0 = wdata;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One complete access on a single port with per-cycle checks of the expected latency.
    task automatic run_access(input logic port, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rd);
        int lat;
        lat = we ? 2 : WAIT + 1;
        set_port(port, 1'b1, we, addr, wdata);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c < lat) begin
                check_eq("acc_mem_read", 32'(mem_read), 32'(!we));
                check_eq("acc_mem_write", 32'(mem_write), 32'(we));
                check_eq("acc_mem_address", mem_address, addr);
                if (we) check_eq("acc_mem_wdata", mem_write_data, wdata);
                check_eq("acc_no_ack", 32'({ack1, ack0}), 32'd0);
            end else begin
                check_eq("done_ack", 32'({ack1, ack0}), port ? 32'd2 : 32'd1);
                check_eq("done_mem_idle", 32'({mem_read, mem_write}), 32'd0);
                if (!we) check_eq("done_rdata", port ? rdata1 : rdata0, exp_rd);
                set_port(port, 1'b0, 1'b0, 32'd0, 32'd0);
            end
        end
        @(negedge clk);
        check_eq("idle_ack", 32'({ack1, ack0}), 32'd0);
        check_eq("idle_mem_address", mem_address, 32'd0);
    endtask

    // Bounded wait for the next ack; reports which port was acknowledged.
    task automatic wait_ack(output logic port);
        logic ok;
        ok = 1'b0;
        port = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                ok = 1'b1;
                port = ack1;
            end
        end
        check_eq("ack_seen", 32'(ok), 32'd1);
        check_eq("ack_onehot", 32'(ack0 & ack1), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic p;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 32'd0; addr1 = 32'd0; wdata0 = 32'd0; wdata1 = 32'd0;
        pre_we = 1'b0; pre_idx = 10'd0; pre_data = 32'd0;

        preload(10'd4, 32'hDEADBEEF);
        preload(10'd16, 32'hA5A5A5A5);

        // Reset state
        check_eq("rst_ack", 32'({ack1, ack0}), 32'd0);
        check_eq("rst_mem_rw", 32'({mem_read, mem_write}), 32'd0);
        check_eq("rst_mem_address", mem_address, 32'd0);
        check_eq("rst_rdata0", rdata0, 32'd0);
        check_eq("rst_rdata1", rdata1, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Port 0 read, WAIT+1 cycle latency
        run_access(1'b0, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF);

        // Port 1 write, then port 0 reads it back
        run_access(1'b1, 1'b1, 32'h20, 32'h12345678, 32'd0);
        check_eq("mem8_written", mem[8], 32'h12345678);
        run_access(1'b0, 1'b0, 32'h20, 32'd0, 32'h12345678);

        // Address change after grant must not reach the memory bus
        set_port(1'b1, 1'b1, 1'b0, 32'h20, 32'd0);
        @(negedge clk);
        check_eq("hold_addr_c1", mem_address, 32'h20);
        addr1 = 32'h40;
        @(negedge clk);
        check_eq("hold_addr_c2", mem_address, 32'h20);
        check_eq("hold_mem_read", 32'(mem_read), 32'd1);
        @(negedge clk);
        check_eq("hold_ack1", 32'(ack1), 32'd1);
        check_eq("hold_rdata1", rdata1, 32'h12345678);
        set_port(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

        // Simultaneous requests after reset: port 0 first, then strict alternation
        do_reset();
        set_port(1'b0, 1'b1, 1'b0, 32'h10, 32'd0);
        set_port(1'b1, 1'b1, 1'b0, 32'h20, 32'd0);
        for (int k = 0; k < 4; k++) begin
            wait_ack(p);
            check_eq("alt_order", 32'(p), 32'(k % 2));
            check_eq("alt_rdata", p ? rdata1 : rdata0, p ? 32'h12345678 : 32'hDEADBEEF);
        end
        set_port(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_port(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        check_eq("alt_end_ack", 32'({ack1, ack0}), 32'd0);

        // Reset during a write's ACCESS cycle aborts it
        set_port(1'b0, 1'b1, 1'b1, 32'h40, 32'h0BADF00D);
        @(negedge clk);
        check_eq("abort_pre_write", 32'(mem_write), 32'd1);
        #1;
        reset = 1'b1;
        set_port(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check_eq("abort_write_low", 32'(mem_write), 32'd0);
        check_eq("abort_addr_zero", mem_address, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check_eq("abort_mem_kept", mem[16], 32'hA5A5A5A5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("abort_no_ack", 32'({ack1, ack0}), 32'd0);
        end
        run_access(1'b0, 1'b0, 32'h40, 32'd0, 32'hA5A5A5A5);

        // Tie after a port-0 grant goes to port 1
        set_port(1'b0, 1'b1, 1'b0, 32'h10, 32'd0);
        set_port(1'b1, 1'b1, 1'b0, 32'h20, 32'd0);
        wait_ack(p);
        check_eq("tie_first", 32'(p), 32'd1);
        set_port(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        wait_ack(p);
        check_eq("tie_second", 32'(p), 32'd0);
        check_eq("tie_rdata0", rdata0, 32'hDEADBEEF);
        set_port(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        run_access(1'b1, 1'b1, 32'h80, 32'h55AA55AA, 32'd0);
        run_access(1'b0, 1'b0, 32'h80, 32'd0, 32'h55AA55AA);
`ifdef MEM_ARB_STATS_EN
        check_eq("stat_grant0", 32'(grant_cnt0), 32'd3);
        check_eq("stat_grant1", 32'(grant_cnt1), 32'd2);
        check_eq("stat_conflict", 32'(conflict_cnt), 32'd1);
`endif
        run_access(1'b0, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF);
`ifdef MEM_ARB_STATS_EN
        check_eq("stat_grant0_sat", 32'(grant_cnt0), 32'd3);
        check_eq("stat_grant1_hold", 32'(grant_cnt1), 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
